// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and arbiter FSM states.
// Commands are packed as {cs_n, ras_n, cas_n, we_n}.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_AREF = 2'd2,
    ST_XFER = 2'd3
  } state_t;

endpackage

// File: rtl/sdram_rr_pick.sv
// One-hot client picker: round-robin after rr_ptr, or fixed priority (ch0 highest).
module sdram_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx
);

  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      // round-robin starts one past the last served channel and wraps
      j = mode ? i : (int'(rr_ptr) + 1 + i) % NUM_CH;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sdram_arbit_mc.sv
// Multi-client SDRAM bus arbiter: init, auto-refresh and NUM_CH clients share one
// command/DQ bus; refresh beats clients and a watchdog bounds every client transfer.
module sdram_arbit_mc
  import sdram_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DQ_W     = 16,
  parameter int ADDR_W   = 13,
  parameter int BANK_W   = 2,
  parameter int ARB_MODE = 0,
  parameter int XFER_TMO = 1023
) (
  input  logic                       sdram_clk,
  input  logic                       sdram_rst,
  input  logic                       init_end,
  input  logic [3:0]                 init_cmd,
  input  logic [BANK_W-1:0]          init_bank,
  input  logic [ADDR_W-1:0]          init_addr,
  input  logic                       ar_req,
  input  logic                       ar_end,
  input  logic [3:0]                 ar_cmd,
  input  logic [BANK_W-1:0]          ar_bank,
  input  logic [ADDR_W-1:0]          ar_addr,
  output logic                       ar_en,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [4*NUM_CH-1:0]        ch_cmd,
  input  logic [BANK_W*NUM_CH-1:0]   ch_bank,
  input  logic [ADDR_W*NUM_CH-1:0]   ch_addr,
  input  logic [DQ_W*NUM_CH-1:0]     ch_wdata,
  input  logic [NUM_CH-1:0]          ch_wdata_en,
  input  logic [NUM_CH-1:0]          ch_end,
  output logic [NUM_CH-1:0]          ch_gnt,
  output logic                       xfer_tmo,
  output logic                       sdram_cke,
  output logic                       sdram_cs_n,
  output logic                       sdram_ras_n,
  output logic                       sdram_cas_n,
  output logic                       sdram_we_n,
  output logic [BANK_W-1:0]          sdram_bank,
  output logic [ADDR_W-1:0]          sdram_addr,
  inout  wire  [DQ_W-1:0]            sdram_dq
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WD_W  = $clog2(XFER_TMO + 1);

  state_t                         state;
  logic [IDX_W-1:0]               gnt_idx, rr_ptr, pick_idx;
  logic [NUM_CH-1:0]              pick_oh;
  logic [WD_W-1:0]                wd_cnt;
  logic [3:0]                     cmd;

  logic [NUM_CH-1:0][3:0]         cmd_v;
  logic [NUM_CH-1:0][BANK_W-1:0]  bank_v;
  logic [NUM_CH-1:0][ADDR_W-1:0]  addr_v;
  logic [NUM_CH-1:0][DQ_W-1:0]    wdata_v;

  assign cmd_v   = ch_cmd;
  assign bank_v  = ch_bank;
  assign addr_v  = ch_addr;
  assign wdata_v = ch_wdata;

  sdram_rr_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .req    (ch_req),
    .rr_ptr (rr_ptr),
    .mode   (ARB_MODE != 0),
    .gnt    (pick_oh),
    .idx    (pick_idx)
  );

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state     <= ST_INIT;
      ch_gnt    <= '0;
      gnt_idx   <= '0;
      ar_en     <= 1'b0;
      xfer_tmo  <= 1'b0;
      rr_ptr    <= '0;
      wd_cnt    <= '0;
      sdram_cke <= 1'b0;
    end else begin
      sdram_cke <= 1'b1;
      xfer_tmo  <= 1'b0;
      case (state)
        ST_INIT: if (init_end) state <= ST_IDLE;
        ST_IDLE: begin
          if (ar_req) begin
            state <= ST_AREF;
            ar_en <= 1'b1;
          end else if (|ch_req) begin
            state   <= ST_XFER;
            ch_gnt  <= pick_oh;
            gnt_idx <= pick_idx;
            wd_cnt  <= '0;
          end
        end
        ST_AREF: begin
          if (ar_end) begin
            state <= ST_IDLE;
            ar_en <= 1'b0;
          end
        end
        ST_XFER: begin
          // a hung client is cut off so a pending refresh can get in
          if (ch_end[gnt_idx] || wd_cnt == WD_W'(XFER_TMO - 1)) begin
            state    <= ST_IDLE;
            ch_gnt   <= '0;
            rr_ptr   <= gnt_idx;
            wd_cnt   <= '0;
            xfer_tmo <= !ch_end[gnt_idx];
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    cmd        = CMD_NOP;
    sdram_bank = '0;
    sdram_addr = '0;
    case (state)
      ST_INIT: begin
        cmd        = init_cmd;
        sdram_bank = init_bank;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        cmd        = ar_cmd;
        sdram_bank = ar_bank;
        sdram_addr = ar_addr;
      end
      ST_XFER: begin
        cmd        = cmd_v[gnt_idx];
        sdram_bank = bank_v[gnt_idx];
        sdram_addr = addr_v[gnt_idx];
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

  assign sdram_dq = (state == ST_XFER && ch_wdata_en[gnt_idx]) ? wdata_v[gnt_idx] : 'z;

endmodule

// File: tb/tb_sdram_arbit_mc.sv
// Scoreboarded bench: round-robin/watchdog instance (dut_a) and fixed-priority instance (dut_b).
module tb_sdram_arbit_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = 4'b0111;
  logic [1:0]  init_bank = '0;
  logic [12:0] init_addr = '0;
  logic        ar_req = 1'b0, ar_end = 1'b0;
  logic [3:0]  ar_cmd = 4'b0001;
  logic [1:0]  ar_bank = 2'd2;
  logic [12:0] ar_addr = 13'h0400;
  logic [3:0]  ch_req = '0, ch_wdata_en = '0, ch_end = '0;
  logic [3:0]  ch_req_b = '0, ch_end_b = '0;
  logic [15:0] ch_cmd   = {4'b0010, 4'b0101, 4'b0100, 4'b0011};
  logic [7:0]  ch_bank  = {2'd3, 2'd2, 2'd1, 2'd0};
  logic [51:0] ch_addr  = {13'h0444, 13'h0333, 13'h0222, 13'h0111};
  logic [63:0] ch_wdata = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};

  logic        ar_en_a, tmo_a, cke_a, cs_a, ras_a, cas_a, we_a;
  logic [3:0]  gnt_a;
  logic [1:0]  bank_a;
  logic [12:0] addr_a;
  wire  [15:0] dq_a;
  logic        ar_en_b, tmo_b, cke_b, cs_b, ras_b, cas_b, we_b;
  logic [3:0]  gnt_b;
  logic [1:0]  bank_b;
  logic [12:0] addr_b;
  wire  [15:0] dq_b;

  wire [3:0] cmd_a = {cs_a, ras_a, cas_a, we_a};

  logic [3:0]  exp_cmd  [4] = '{4'b0011, 4'b0100, 4'b0101, 4'b0010};
  logic [12:0] exp_addr [4] = '{13'h0111, 13'h0222, 13'h0333, 13'h0444};
  logic [1:0]  exp_bank [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

  always #5 clk = ~clk;

  sdram_arbit_mc #(.NUM_CH(4), .DQ_W(16), .ADDR_W(13), .BANK_W(2), .ARB_MODE(0), .XFER_TMO(16)) dut_a (
    .sdram_clk(clk), .sdram_rst(rst), .init_end(init_end), .init_cmd(init_cmd),
    .init_bank(init_bank), .init_addr(init_addr), .ar_req(ar_req), .ar_end(ar_end),
    .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr), .ar_en(ar_en_a),
    .ch_req(ch_req), .ch_cmd(ch_cmd), .ch_bank(ch_bank), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_wdata_en(ch_wdata_en), .ch_end(ch_end), .ch_gnt(gnt_a),
    .xfer_tmo(tmo_a), .sdram_cke(cke_a), .sdram_cs_n(cs_a), .sdram_ras_n(ras_a),
    .sdram_cas_n(cas_a), .sdram_we_n(we_a), .sdram_bank(bank_a), .sdram_addr(addr_a),
    .sdram_dq(dq_a)
  );

  sdram_arbit_mc #(.NUM_CH(4), .DQ_W(16), .ADDR_W(13), .BANK_W(2), .ARB_MODE(1), .XFER_TMO(16)) dut_b (
    .sdram_clk(clk), .sdram_rst(rst), .init_end(init_end), .init_cmd(init_cmd),
    .init_bank(init_bank), .init_addr(init_addr), .ar_req(ar_req), .ar_end(ar_end),
    .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr), .ar_en(ar_en_b),
    .ch_req(ch_req_b), .ch_cmd(ch_cmd), .ch_bank(ch_bank), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_wdata_en(4'b0000), .ch_end(ch_end_b), .ch_gnt(gnt_b),
    .xfer_tmo(tmo_b), .sdram_cke(cke_b), .sdram_cs_n(cs_b), .sdram_ras_n(ras_b),
    .sdram_cas_n(cas_b), .sdram_we_n(we_b), .sdram_bank(bank_b), .sdram_addr(addr_b),
    .sdram_dq(dq_b)
  );

  typedef struct packed { logic [1:0] kind; logic [3:0] val; } ev_t;  // kind: 0 grant, 1 refresh, 2 watchdog
  ev_t q_a[$];
  ev_t q_b[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic sb_check(input bit b, input ev_t got);
    ev_t e;
    if ((b && q_b.size() == 0) || (!b && q_a.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected_%s actual=%h expected=none t=%0t", b ? "b" : "a", got, $time);
    end else begin
      e = b ? q_b.pop_front() : q_a.pop_front();
      chk(b ? "sb_event_b" : "sb_event_a", 32'(got), 32'(e));
    end
  endtask

  // monitor: decoupled from stimulus, pops one expectation per observed event
  logic [3:0] pg_a = '0, pg_b = '0;
  logic       par_a = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (gnt_a !== 4'b0 && pg_a === 4'b0) sb_check(1'b0, {2'd0, gnt_a});
        if (ar_en_a === 1'b1 && par_a === 1'b0) sb_check(1'b0, {2'd1, 4'd0});
        if (tmo_a === 1'b1) sb_check(1'b0, {2'd2, 4'd0});
        if (gnt_b !== 4'b0 && pg_b === 4'b0) sb_check(1'b1, {2'd0, gnt_b});
      end
      pg_a  = gnt_a;
      pg_b  = gnt_b;
      par_a = ar_en_a;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_gnt(input bit b, output int k);
    k = 0;
    for (int n = 0; n < 50; n++) begin
      if ((b ? gnt_b : gnt_a) !== 4'b0) begin
        for (int i = 0; i < 4; i++) if ((b ? gnt_b[i] : gnt_a[i]) === 1'b1) k = i;
        return;
      end
      cyc();
    end
    chk("grant_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int k, cnt;
    // reset state
    repeat (3) cyc();
    chk("rst_cke", cke_a, 0);
    chk("rst_gnt", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_ar_en", ar_en_a, 0);
    chk("rst_tmo", tmo_a, 0);
    rst = 1'b0;

    // INIT mirrors init engine until init_end at cycle 20
    for (int c = 0; c <= 20; c++) begin
      cyc();
      if (c == 0) chk("cke_out_of_rst", cke_a, 1);
      init_cmd  = 4'(c) ^ 4'b1000;
      init_bank = 2'(c);
      init_addr = 13'(c * 3 + 1);
      #1;
      chk("init_cmd_mirror", cmd_a, init_cmd);
      chk("init_addr_mirror", addr_a, init_addr);
      if (c == 20) init_end = 1'b1;
    end
    cyc();
    chk("idle_nop_cmd", cmd_a, 4'b0111);
    chk("idle_nop_addr", {bank_a, addr_a}, 0);
    init_end = 1'b0;
    cyc();
    chk("init_end_fall_ignored", cmd_a, 4'b0111);

    // round-robin with all four requesting
    ch_req = 4'b1111;
    q_a.push_back({2'd0, 4'b0010});
    q_a.push_back({2'd0, 4'b0100});
    q_a.push_back({2'd0, 4'b1000});
    q_a.push_back({2'd0, 4'b0001});
    q_a.push_back({2'd0, 4'b0010});
    for (int g = 0; g < 5; g++) begin
      wait_gnt(1'b0, k);
      chk("xfer_cmd", cmd_a, exp_cmd[k]);
      chk("xfer_addr", addr_a, exp_addr[k]);
      chk("xfer_bank", bank_a, exp_bank[k]);
      repeat (4) cyc();
      ch_end[k] = 1'b1;
      if (g == 4) ch_req = 4'b0000;
      cyc();
      ch_end = '0;
      chk("rr_gap_gnt", gnt_a, 0);
      chk("rr_gap_nop", cmd_a, 4'b0111);
    end

    // fixed priority: ch1 always beats ch3
    ch_req_b = 4'b1010;
    repeat (4) q_b.push_back({2'd0, 4'b0010});
    for (int g = 0; g < 4; g++) begin
      wait_gnt(1'b1, k);
      chk("fp_gnt", gnt_b, 4'b0010);
      repeat (2) cyc();
      ch_end_b[k] = 1'b1;
      if (g == 3) ch_req_b = 4'b0000;
      cyc();
      ch_end_b = '0;
    end
    cyc();

    // refresh and client request in the same IDLE cycle
    ar_req = 1'b1;
    ch_req = 4'b0100;
    q_a.push_back({2'd1, 4'd0});
    q_a.push_back({2'd0, 4'b0100});
    cyc();
    chk("aref_en", ar_en_a, 1);
    chk("aref_no_gnt", gnt_a, 0);
    chk("aref_cmd", cmd_a, 4'b0001);
    chk("aref_addr", {bank_a, addr_a}, {2'd2, 13'h0400});
    ar_req = 1'b0;
    repeat (2) cyc();
    ar_end = 1'b1;
    cyc();
    ar_end = 1'b0;
    chk("aref_exit_en", ar_en_a, 0);
    chk("aref_exit_gnt", gnt_a, 0);
    chk("aref_exit_nop", cmd_a, 4'b0111);
    cyc();
    chk("gnt_after_aref", gnt_a, 4'b0100);
    ch_end[2] = 1'b1;
    ch_req = 4'b0000;
    cyc();
    ch_end = '0;
    chk("ch2_released", gnt_a, 0);
    cyc();

    // watchdog: ch3 never ends
    ch_req = 4'b1000;
    ch_wdata_en = 4'b1000;
    q_a.push_back({2'd0, 4'b1000});
    q_a.push_back({2'd2, 4'd0});
    wait_gnt(1'b0, k);
    chk("wd_dq_drive", dq_a, 16'hD3D3);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      cyc();
      cnt++;
      if (cnt == 8) chk("wd_gnt_held", gnt_a, 4'b1000);
      if (tmo_a === 1'b1) break;
    end
    chk("wd_tmo_cycle", cnt, 16);
    chk("wd_gnt_drop", gnt_a, 0);
    chk("wd_dq_z", dq_a === 16'hzzzz, 1);
    chk("wd_nop", cmd_a, 4'b0111);
    ch_req = 4'b0000;
    ch_wdata_en = 4'b0000;
    cyc();
    chk("wd_tmo_pulse", tmo_a, 0);

    // write on ch1, then reset mid-transfer
    ch_req = 4'b0010;
    ch_wdata_en = 4'b0010;
    q_a.push_back({2'd0, 4'b0010});
    wait_gnt(1'b0, k);
    chk("wr_cmd", cmd_a, 4'b0100);
    chk("wr_dq", dq_a, 16'hB1B1);
    rst = 1'b1;
    cyc();
    chk("rst_mid_gnt", gnt_a, 0);
    chk("rst_mid_dq_z", dq_a === 16'hzzzz, 1);
    chk("rst_mid_cke", cke_a, 0);
    chk("rst_mid_init_cmd", cmd_a, init_cmd);
    rst = 1'b0;
    repeat (3) cyc();
    chk("init_blocks_req", gnt_a, 0);
    chk("init_cke", cke_a, 1);
    ch_req = 4'b0000;
    ch_wdata_en = 4'b0000;
    cyc();

    chk("sb_a_drained", q_a.size(), 0);
    chk("sb_b_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
